// File: rtl/ddr2_pkg.sv
// Shared types for the DDR2 MIG arbiter: FSM state encoding and
// MIG application command codes.
package ddr2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_XFER = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_e;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

endpackage

// File: rtl/ddr2_arb_select.sv
// Grant decision between capture writes and readout reads, with a
// write-run counter that bounds write streaks while a read waits.
module ddr2_arb_select
    import ddr2_pkg::*;
#(
    parameter int unsigned WR_BURST_MAX = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic idle_i,
    input  logic calib_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    localparam int unsigned RW = $clog2(WR_BURST_MAX + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(WR_BURST_MAX);

    logic [RW-1:0] wr_run_q;
    logic [RW-1:0] wr_run_d;
    logic          open;

    always_comb begin
        open     = idle_i & calib_i;
        gnt_wr_o = 1'b0;
        gnt_rd_o = 1'b0;
        if (open) begin
            if (wr_req_i && (!rd_req_i || wr_run_q < RUN_MAX)) begin
                gnt_wr_o = 1'b1;
            end else if (rd_req_i) begin
                gnt_rd_o = 1'b1;
            end
        end
        wr_run_d = wr_run_q;
        if (gnt_rd_o) begin
            wr_run_d = '0;
        end else if (gnt_wr_o && wr_run_q != RUN_MAX) begin
            wr_run_d = wr_run_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_run_q <= '0;
        end else begin
            wr_run_q <= wr_run_d;
        end
    end

endmodule

// File: rtl/ddr2_arbiter.sv
// Single-port arbiter in front of the MIG DDR2 application interface:
// one burst write or one burst read in flight at a time.
module ddr2_arbiter
    import ddr2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 27,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned WR_BURST_MAX = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    init_calib_complete,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ack,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_ack,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    output logic                    busy,
    output logic                    rd_err
);

    arb_state_e            state_q;
    logic [ADDR_WIDTH-1:0] app_addr_q;
    logic [2:0]            app_cmd_q;
    logic                  app_en_q;
    logic [DATA_WIDTH-1:0] wdf_data_q;
    logic                  wdf_wren_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  rd_err_q;
    logic                  idle;
    logic                  gnt_wr;
    logic                  gnt_rd;

    assign idle = (state_q == IDLE);

    ddr2_arb_select #(
        .WR_BURST_MAX(WR_BURST_MAX)
    ) u_select (
        .clk      (clk),
        .resetn   (resetn),
        .idle_i   (idle),
        .calib_i  (init_calib_complete),
        .wr_req_i (wr_req),
        .rd_req_i (rd_req),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            app_addr_q <= '0;
            app_cmd_q  <= '0;
            app_en_q   <= 1'b0;
            wdf_data_q <= '0;
            wdf_wren_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (app_rd_data_valid && state_q != RD_WAIT) begin
                rd_err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt_wr) begin
                        app_addr_q <= wr_addr;
                        app_cmd_q  <= APP_CMD_WR;
                        app_en_q   <= 1'b1;
                        wdf_data_q <= wr_data;
                        wdf_wren_q <= 1'b1;
                        state_q    <= WR_XFER;
                    end else if (gnt_rd) begin
                        app_addr_q <= rd_addr;
                        app_cmd_q  <= APP_CMD_RD;
                        app_en_q   <= 1'b1;
                        state_q    <= RD_CMD;
                    end
                end
                WR_XFER: begin
                    // Command and data channels retire independently.
                    if (app_rdy) begin
                        app_en_q <= 1'b0;
                    end
                    if (app_wdf_rdy) begin
                        wdf_wren_q <= 1'b0;
                    end
                    if ((!app_en_q || app_rdy) &&
                        (!wdf_wren_q || app_wdf_rdy)) begin
                        state_q <= IDLE;
                    end
                end
                RD_CMD: begin
                    if (app_rdy) begin
                        app_en_q <= 1'b0;
                        state_q  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        rd_data_q  <= app_rd_data;
                        rd_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ack       = gnt_wr;
    assign rd_ack       = gnt_rd;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign app_addr     = app_addr_q;
    assign app_cmd      = app_cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_data = wdf_data_q;
    assign app_wdf_mask = '0;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_wren_q;
    assign busy         = ~idle;
    assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_ddr2_arbiter.sv
// Scoreboard bench for ddr2_arbiter: directed scenarios plus a random
// soak against a transaction-level model and a simple MIG responder.
module tb_ddr2_arbiter;

    localparam int AW  = 27;
    localparam int DW  = 128;
    localparam int WBM = 8;

    logic          clk;
    logic          resetn;
    logic          init_calib_complete;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          busy;
    logic          rd_err;

    ddr2_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WR_BURST_MAX(WBM)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .init_calib_complete (init_calib_complete),
        .wr_req              (wr_req),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_ack              (wr_ack),
        .rd_req              (rd_req),
        .rd_addr             (rd_addr),
        .rd_ack              (rd_ack),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .busy                (busy),
        .rd_err              (rd_err)
    );

    int checks = 0;
    int passes = 0;

    // scoreboard queues
    logic [AW-1:0] wcq[$];
    logic [DW-1:0] wdq[$];
    logic [AW-1:0] rcq[$];
    logic [DW-1:0] rdq[$];
    logic          rd_out = 1'b0;
    int            wrun = 0;

    // MIG responder controls
    logic          mig_auto = 1'b0;
    logic          rdy_rand = 1'b0;
    int            rd_lat = 1;
    int            rd_cnt = 0;
    logic          use_fixed = 1'b0;
    logic [DW-1:0] fixed_data = '0;
    logic          man_rdy = 1'b0;
    logic          man_wdf_rdy = 1'b0;
    logic          man_rvalid = 1'b0;
    logic [DW-1:0] man_rdata = '0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // MIG model: command/data ready and read return after a latency
    initial begin
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rd_cnt = 0;
                rdq.delete();
            end else if (app_en && app_rdy && app_cmd == 3'b001) begin
                chk("single_read_outstanding", rd_cnt != 0, 0);
                rd_cnt = (rd_lat != 0) ? rd_lat : $urandom_range(1, 12);
            end
            @(posedge clk);
            #2;
            app_rd_data_valid = 1'b0;
            if (!resetn) rd_cnt = 0;
            if (mig_auto) begin
                app_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                app_wdf_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        app_rd_data = use_fixed ? fixed_data : rnd_data();
                        app_rd_data_valid = 1'b1;
                        rdq.push_back(app_rd_data);
                    end
                end
            end else begin
                app_rdy = man_rdy;
                app_wdf_rdy = man_wdf_rdy;
                app_rd_data_valid = man_rvalid;
                app_rd_data = man_rdata;
            end
        end
    end

    // Monitor: grant rules and transaction contents
    initial begin
        logic outstanding;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                wcq.delete();
                wdq.delete();
                rcq.delete();
                rd_out = 1'b0;
                wrun = 0;
            end else begin
                if (rd_valid) begin
                    if (rdq.size() == 0) chk("rd_valid_unexpected", 1, 0);
                    else chk("rd_data", rd_data, rdq.pop_front());
                    rd_out = 1'b0;
                end
                if (wr_ack || rd_ack) begin
                    outstanding = (wcq.size() + wdq.size() + rcq.size() != 0)
                                  || rd_out;
                    chk("grant_onehot", wr_ack & rd_ack, 0);
                    chk("grant_calib", init_calib_complete, 1);
                    chk("grant_while_busy", outstanding, 0);
                    chk("grant_kind", wr_ack,
                        wr_req && (!rd_req || wrun < WBM));
                    if (wr_ack) begin
                        wcq.push_back(wr_addr);
                        wdq.push_back(wr_data);
                        wrun = (wrun < WBM) ? wrun + 1 : WBM;
                    end else begin
                        rcq.push_back(rd_addr);
                        rd_out = 1'b1;
                        wrun = 0;
                    end
                end
                if (app_en && app_rdy) begin
                    if (app_cmd == 3'b001) begin
                        if (rcq.size() == 0) chk("rd_cmd_unexpected", 1, 0);
                        else chk("rd_cmd_addr", app_addr, rcq.pop_front());
                    end else begin
                        chk("wr_cmd_code", app_cmd, 0);
                        if (wcq.size() == 0) chk("wr_cmd_unexpected", 1, 0);
                        else chk("wr_cmd_addr", app_addr, wcq.pop_front());
                    end
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    chk("wdf_end", app_wdf_end, 1);
                    chk("wdf_mask", app_wdf_mask, 0);
                    if (wdq.size() == 0) chk("wdf_unexpected", 1, 0);
                    else chk("wdf_data", app_wdf_data, wdq.pop_front());
                end
            end
        end
    end

    initial begin
        int n_ack;
        int n_en;
        int n_busy;
        int got;
        logic seen;
        logic [26:0] kinds;
        logic [26:0] expk;

        resetn = 1'b0;
        init_calib_complete = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {wr_ack, rd_ack, app_en, app_wdf_wren, app_wdf_end,
                          rd_valid, busy, rd_err}, 0);
        chk("rst_addr_cmd", {app_addr, app_cmd}, 0);
        chk("rst_rd_data", rd_data, 0);
        tick();
        resetn = 1'b1;
        init_calib_complete = 1'b1;

        // single write, MIG always ready
        mig_auto = 1'b1;
        rdy_rand = 1'b0;
        tick();
        wr_req = 1'b1;
        wr_addr = AW'(32'h40);
        wr_data = {16{8'hA5}};
        @(negedge clk);
        chk("t37_ack", wr_ack, 1);
        for (int c = 1; c <= 2; c++) begin
            tick();
            wr_req = 1'b0;
            @(negedge clk);
            chk("t37_en", app_en, c == 1);
            chk("t37_wren", app_wdf_wren, c == 1);
            if (c == 1) chk("t37_addr_cmd", {app_addr, app_cmd},
                            {AW'(32'h40), 3'b000});
        end

        // command channel stalled until cycle 4
        mig_auto = 1'b0;
        man_rdy = 1'b0;
        man_wdf_rdy = 1'b1;
        tick();
        wr_req = 1'b1;
        wr_addr = rnd_addr();
        wr_data = rnd_data();
        @(negedge clk);
        chk("t38_ack", wr_ack, 1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            wr_req = 1'b0;
            man_rdy = (c == 4);
            @(negedge clk);
            chk("t38_en", app_en, c <= 4);
            chk("t38_wren", app_wdf_wren, c == 1);
            chk("t38_busy", busy, c <= 4);
        end

        // read with 10-cycle return, rd_req held
        mig_auto = 1'b1;
        rd_lat = 10;
        use_fixed = 1'b1;
        fixed_data = 128'h1234;
        tick();
        rd_req = 1'b1;
        rd_addr = AW'(32'h100);
        n_ack = 0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                seen = 1'b1;
                chk("t39_data", rd_data, 128'h1234);
            end else if (rd_ack) begin
                n_ack++;
            end
            if (!seen) tick();
        end
        chk("t39_valid_seen", seen, 1);
        chk("t39_acks_before_valid", n_ack, 1);
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t39_valid_pulse", rd_valid, 0);
        use_fixed = 1'b0;
        repeat (30) tick();

        // both requests held: 8 writes then 1 read
        rd_lat = 2;
        wr_req = 1'b1;
        rd_req = 1'b1;
        got = 0;
        kinds = '0;
        for (int c = 0; c < 600 && got < 27; c++) begin
            wr_addr = rnd_addr();
            wr_data = rnd_data();
            rd_addr = rnd_addr();
            @(negedge clk);
            if (wr_ack || rd_ack) begin
                kinds[got] = rd_ack;
                got++;
            end
            tick();
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        for (int i = 0; i < 27; i++) expk[i] = (i % 9 == 8);
        chk("t40_grants", got, 27);
        chk("t40_pattern", kinds, expk);
        repeat (40) tick();

        // no grants before calibration
        init_calib_complete = 1'b0;
        tick();
        wr_req = 1'b1;
        rd_req = 1'b1;
        n_ack = 0;
        n_en = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_ack || rd_ack) n_ack++;
            if (app_en) n_en++;
            tick();
        end
        chk("t41_no_ack", n_ack, 0);
        chk("t41_no_en", n_en, 0);
        init_calib_complete = 1'b1;
        @(negedge clk);
        chk("t41_first_grant", wr_ack | rd_ack, 1);
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (40) tick();

        // calibration lost mid-write: finish it, then hold off
        mig_auto = 1'b0;
        man_rdy = 1'b0;
        man_wdf_rdy = 1'b0;
        tick();
        wr_req = 1'b1;
        wr_addr = rnd_addr();
        wr_data = rnd_data();
        @(negedge clk);
        chk("t31_ack", wr_ack, 1);
        tick();
        init_calib_complete = 1'b0;
        repeat (3) tick();
        man_rdy = 1'b1;
        man_wdf_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        man_wdf_rdy = 1'b0;
        n_ack = 0;
        n_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_ack) n_ack++;
            if (busy) n_busy++;
            tick();
        end
        chk("t31_no_grant", n_ack, 0);
        chk("t31_done", n_busy, 0);
        init_calib_complete = 1'b1;
        @(negedge clk);
        chk("t31_regrant", wr_ack, 1);
        tick();
        wr_req = 1'b0;
        man_rdy = 1'b1;
        man_wdf_rdy = 1'b1;
        repeat (5) tick();
        chk("rd_err_clean", rd_err, 0);

        // reset during RD_WAIT, then a stray read return
        mig_auto = 1'b1;
        rd_lat = 40;
        tick();
        rd_req = 1'b1;
        rd_addr = rnd_addr();
        @(negedge clk);
        chk("t42_ack", rd_ack, 1);
        tick();
        rd_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("t42_in_wait", {busy, app_en}, 2'b10);
        mig_auto = 1'b0;
        man_rdy = 1'b0;
        man_wdf_rdy = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t42_rst_flags", {busy, app_en, rd_valid, rd_ack, wr_ack, rd_err}, 0);
        chk("t42_rst_addr", app_addr, 0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        man_rvalid = 1'b1;
        man_rdata = rnd_data();
        tick();
        man_rvalid = 1'b0;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_valid) n_ack++;
            tick();
        end
        chk("t42_no_valid", n_ack, 0);
        chk("t42_rd_err", rd_err, 1);
        chk("t42_rd_data", rd_data, 0);
        chk("t42_idle", busy, 0);

        // random soak
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_clears_rd_err", rd_err, 0);
        mig_auto = 1'b1;
        rdy_rand = 1'b1;
        rd_lat = 0;
        tick();
        for (int c = 0; c < 2500; c++) begin
            wr_req = $urandom_range(0, 1);
            rd_req = ($urandom_range(0, 2) == 0);
            wr_addr = rnd_addr();
            wr_data = rnd_data();
            rd_addr = rnd_addr();
            if (init_calib_complete) begin
                if ($urandom_range(0, 59) == 0) init_calib_complete = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                init_calib_complete = 1'b1;
            end
            tick();
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        init_calib_complete = 1'b1;
        repeat (60) tick();
        chk("sb_drained", wcq.size() + wdq.size() + rcq.size() + rdq.size(), 0);
        chk("sb_no_read_left", rd_out, 0);
        chk("soak_rd_err", rd_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
